// File: rtl/alu2_result_queue.sv
// rtl/alu2_result_queue.sv - registered FIFO output stage for the ALU result word with parity and counters
module alu2_result_queue #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_parity,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           accepted,
  output logic [CNT_W-1:0]           full_hits
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Reject depths the pointer arithmetic cannot wrap cleanly and empty counters
  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2) || (DEPTH > 16) || (CNT_W < 1)) begin : g_bad_params
    $error("alu2_result_queue: DEPTH must be a power of two in 2..16 and CNT_W >= 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;
  logic [CNT_W-1:0] full_hits_q, full_hits_d;
  logic             full;
  logic             push;
  logic             pop;

  // Handshake qualifiers; in_ready depends on stored level only, so a pop never frees a slot in the same cycle
  always_comb begin
    full      = (level_q == FULL_LVL);
    in_ready  = !full;
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for pointers, occupancy and counters
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    accepted_d  = accepted_q;
    full_hits_d = full_hits_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      accepted_d = accepted_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    // Stalled offers against a full queue; saturate so a long stall stays visible
    if (in_valid && full && (full_hits_q != {CNT_W{1'b1}})) begin
      full_hits_d = full_hits_q + 1'b1;
    end
  end

  // Control state register; reset wins over any handshake in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      accepted_q  <= '0;
      full_hits_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      accepted_q  <= accepted_d;
      full_hits_q <= full_hits_d;
    end
  end

  // Storage write; contents are don't-care after reset so no reset term, but a reset cycle never writes
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Head presentation; data and parity are forced low while empty
  always_comb begin
    out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    out_parity = ^out_data;
    level      = level_q;
    accepted   = accepted_q;
    full_hits  = full_hits_q;
  end

endmodule

// File: tb/tb_alu2_result_queue.sv
// tb/tb_alu2_result_queue.sv - directed self-checking bench for alu2_result_queue
module tb_alu2_result_queue;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;

  logic       in_ready, out_valid, out_parity;
  logic [5:0] out_data;
  logic [2:0] level;
  logic [7:0] accepted, full_hits;

  logic       in_ready4, out_valid4, out_parity4;
  logic [5:0] out_data4;
  logic [2:0] level4;
  logic [3:0] accepted4, full_hits4;

  int tests_run;
  int tests_failed;

  logic [5:0] drain_exp [4];
  logic       drain_par [4];

  alu2_result_queue #(.WIDTH(6), .DEPTH(4), .CNT_W(8)) u_dut (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .level(level),
    .accepted(accepted), .full_hits(full_hits)
  );

  alu2_result_queue #(.WIDTH(6), .DEPTH(4), .CNT_W(4)) u_dut4 (
    .clock(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_parity(out_parity4), .level(level4),
    .accepted(accepted4), .full_hits(full_hits4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    drain_exp[0] = 6'h01; drain_par[0] = 1'b1;
    drain_exp[1] = 6'h02; drain_par[1] = 1'b1;
    drain_exp[2] = 6'h03; drain_par[2] = 1'b0;
    drain_exp[3] = 6'h04; drain_par[3] = 1'b1;

    reset = 1'b1; in_valid = 1'b0; in_data = 6'h00; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_parity", out_parity, 0);
    check_eq("rst_accepted", accepted, 0);
    check_eq("rst_full_hits", full_hits, 0);

    // single push, no fall-through before the edge
    in_valid = 1'b1; in_data = 6'h2A;
    check_eq("pre_push_out_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check_eq("p1_out_valid", out_valid, 1);
    check_eq("p1_out_data", out_data, 32'h2A);
    check_eq("p1_out_parity", out_parity, 1);
    check_eq("p1_level", level, 1);
    check_eq("p1_accepted", accepted, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("p1_drained_level", level, 0);

    // fill, then offer 0x3F against a full queue
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 6'(i);
      tick();
    end
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_level", level, 4);
    in_data = 6'h3F;
    repeat (3) tick();
    in_valid = 1'b0;
    check_eq("full_hits_3", full_hits, 3);
    check_eq("full_accepted", accepted, 5);
    check_eq("full_level_held", level, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", out_data, drain_exp[i]);
      check_eq("drain_parity", out_parity, drain_par[i]);
      tick();
    end
    out_ready = 1'b0;
    check_eq("drain_empty_valid", out_valid, 0);
    check_eq("drain_empty_data", out_data, 0);
    check_eq("drain_empty_level", level, 0);

    // prime one word, then streaming push+pop
    in_valid = 1'b1; in_data = 6'h10;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 6'(k);
      check_eq("stream_head", out_data, (k == 0) ? 32'h10 : 32'(k - 1));
      tick();
      check_eq("stream_level", level, 1);
    end
    in_valid = 1'b0;
    check_eq("stream_last", out_data, 9);
    tick();
    out_ready = 1'b0;
    check_eq("stream_empty", level, 0);
    check_eq("stream_accepted", accepted, 16);

    // reset while holding data and handshaking
    for (int i = 5; i <= 7; i++) begin
      in_valid = 1'b1; in_data = 6'(i);
      tick();
    end
    check_eq("pre_rst_level", level, 3);
    reset = 1'b1; in_valid = 1'b1; in_data = 6'h15; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_accepted", accepted, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    in_valid = 1'b1; in_data = 6'h22;
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_head", out_data, 32'h22);
    check_eq("post_rst_level", level, 1);

    // counter wrap and saturation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 6'(i);
      tick();
    end
    check_eq("wrap_accepted4", accepted4, 1);
    check_eq("wrap_accepted8", accepted, 17);
    check_eq("wrap_level4", level4, 1);
    check_eq("wrap_head4", out_data4, 16);
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("sat_full4", level4, 4);
    check_eq("sat_in_ready4", in_ready4, 0);
    repeat (20) tick();
    in_valid = 1'b0;
    check_eq("sat_full_hits4", full_hits4, 15);
    check_eq("sat_full_hits8", full_hits, 20);
    check_eq("sat_accepted4", accepted4, 4);
    check_eq("sat_accepted8", accepted, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu2_result_queue.md
Name: alu2_result_queue

Overview:
- Registered output stage placed directly downstream of the combinational alu4_cl result logic.
- Captures the 6-bit result word (po5..po0 packed as in_data[5:0]) under a valid/ready handshake and buffers it in a small FIFO.
- Presents each word with an even-parity bit to the consumer and keeps occupancy and throughput counters for the bench and debug.

Parameters:
- WIDTH, 6, result word width; must match the ALU output count.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clock, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, upstream word present.
- in_ready, output, 1, queue can accept; equals (level != DEPTH).
- in_data, input, WIDTH, result word, bit i = po<i>.
- out_valid, output, 1, head word present.
- out_ready, input, 1, consumer accepts head.
- out_data, output, WIDTH, head word.
- out_parity, output, 1, XOR of out_data bits; 0 when empty.
- level, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
- accepted, output, CNT_W, count of words accepted since reset.
- full_hits, output, CNT_W, cycles with in_valid=1 while full.

Behaviour:
- Reset (reset=1 at a clock edge):
  - level=0, out_valid=0, out_data=0, out_parity=0, accepted=0, full_hits=0.
  - Read and write pointers go to 0. Storage contents are don't-care.
  - Reset overrides any handshake in the same cycle.
- Push occurs when in_valid & in_ready. The word is written at wr_ptr, then wr_ptr advances modulo DEPTH.
- Pop occurs when out_valid & out_ready. rd_ptr advances modulo DEPTH.
- Outputs are combinational from registered state:
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr], forced to 0 when empty.
  - in_ready = (level != DEPTH).
- Latency: a word pushed at edge N is visible on out_data after edge N (one cycle). There is no fall-through when empty.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both in the same cycle: unchanged, and both pointers advance.
- Full (level=DEPTH):
  - in_ready=0 and no push occurs.
  - A simultaneous pop does not enable a push in that cycle, because in_ready is not combinationally tied to out_ready.
- Empty (level=0): out_valid=0 and a pop cannot occur. A push proceeds normally.
- Pointers wrap from DEPTH-1 to 0 with no gap. Word order is strict FIFO.
- accepted increments by 1 per push and wraps modulo 2^CNT_W.
- full_hits increments when in_valid=1 and level=DEPTH, and saturates at 2^CNT_W-1 (no wrap).
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. The queue does not check this.
- Unknown or X on in_data is stored as-is. Parity is computed on read.
- Bus contents while invalid are don't-care on input, and out_data is 0 when out_valid=0.
- Parameter checks: DEPTH must be a power of two and CNT_W ≥ 1. A violation causes an elaboration-time error.

Test Plan:
- Reset, then idle 3 cycles -> out_valid=0, level=0, in_ready=1, out_data=0, out_parity=0, accepted=0.
- Push 0x2A with out_ready=0 -> on the next cycle out_valid=1, out_data=0x2A, out_parity=1, level=1, accepted=1.
- Push 0x01, 0x02, 0x03, 0x04 back-to-back with out_ready=0, then hold in_valid=1 with 0x3F for 3 cycles:
  - in_ready=0 after the 4th push, level=4, full_hits=3.
  - Then drain with out_ready=1 -> outputs 0x01, 0x02, 0x03, 0x04 in order and 0x3F is never stored.
- Continuous push/pop, in_valid=out_ready=1 for 10 cycles with data 0..9 after one primed word:
  - level stays 1.
  - Output sequence lags input by one.
  - Pointers wrap twice with no loss or duplication.
- Fill to 3 entries, then assert reset for 1 cycle together with in_valid=1 and out_ready=1 -> level=0, out_valid=0, accepted=0, and no word from that cycle appears later.
- With CNT_W=4, push 17 words with concurrent pops -> accepted wraps to 1. Hold the queue full with in_valid=1 for 20 cycles -> full_hits saturates at 15.
